// File: rtl/cla_multicycle_adder_ctrl.sv
// cla_multicycle_adder_ctrl
// Adds two W-bit operands over W/4 cycles. A single 4-bit carry look-ahead
// slice is reused every cycle, starting with the LSB slice. The carry between
// slices is held in a register, so no combinational carry path crosses a slice.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - begin an add; sampled only while ready=1
//   a, b   - W-bit operands, captured on the accepting edge
//   cin    - carry-in to the LSB slice, captured on the accepting edge
//   ready  - high only in IDLE
//   done   - one-cycle pulse when the result is valid
//   sum    - W-bit result, held until the next accepted start
//   cout   - carry out of the MSB slice
//   ovf    - two's-complement overflow
//   zero   - sum == 0
module cla_multicycle_adder_ctrl #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned NS = W / 4;
  localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;

  // Reject widths that do not split into whole 4-bit slices
  generate
    if ((W % 4) != 0 || W < 4) begin : g_bad_width
      $error("cla_multicycle_adder_ctrl: W must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;

  logic [3:0]    slice_a;
  logic [3:0]    slice_b;
  logic [3:0]    slice_s;
  logic          slice_c;
  logic [W-1:0]  sum_nx;
  logic          last;

  // 4-bit carry look-ahead block: all four carries from generate/propagate terms
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1, c2, c3, c4;
    p  = x ^ y;
    g  = x & y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

  // Current slice datapath; sum_nx is sum with the current slice merged in
  always_comb begin
    slice_a            = a_reg[{idx, 2'b00} +: 4];
    slice_b            = b_reg[{idx, 2'b00} +: 4];
    {slice_c, slice_s} = cla4(slice_a, slice_b, carry);
    sum_nx             = sum;
    sum_nx[{idx, 2'b00} +: 4] = slice_s;
    last               = (idx == IW'(NS - 1));
  end

  // Sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            sum   <= '0;
            idx   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_nx;
          carry <= slice_c;
          idx   <= idx + IW'(1);
          if (last) begin
            cout  <= slice_c;
            ovf   <= (a_reg[W-1] == b_reg[W-1]) && (sum_nx[W-1] != a_reg[W-1]);
            zero  <= (sum_nx == '0);
            done  <= 1'b1;
            idx   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
